imem_loader: RTL and testbench

- Byte-stream program loader that drives the write port of the instruction memory (write address, write data, write enable).
- Takes a framed byte stream on a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them to consecutive addresses.
- Raises `busy` while loading so the core can be held off. Reports `done` or `error` on completion.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// Pure definitions: no logic, no latency, no flow control.
package imem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = 32;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word and keeps a running XOR checksum.
// Updates on the accepting edge; word_full flags that the current beat completes a word.
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic [7:0]  chk,
    output logic        word_full
);

    localparam int BI_W = $clog2(WORD_BYTES);

    logic [BI_W-1:0] byte_idx;

    assign word_full = (byte_idx == BI_W'(WORD_BYTES - 1));

    // byte_idx wraps to 0 on the last byte, so the next word starts clean after WRITE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            word     <= '0;
            chk      <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            chk      <= '0;
        end else if (accept) begin
            word[{byte_idx, 3'b000} +: 8] <= in_data;
            chk                           <= chk ^ in_data;
            byte_idx                      <= byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader driving the instruction-memory write port; word write one cycle after its last byte.
// in_ready depends only on state (low in IDLE/WRITE/DONE/ERROR), so the stream stalls during each write.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int BASE_ADDR = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [IMEM_AW-1:0] WriteReg,
    output logic [31:0]        WriteData,
    output logic               RegWrite,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int                 WIDX_W  = $clog2(DEPTH) + 1;
    localparam logic [15:0]        DEPTH_W = 16'(DEPTH);
    localparam logic [IMEM_AW-1:0] BASE_W  = IMEM_AW'(BASE_ADDR);

    state_t             state;
    state_t             state_nxt;
    logic               hdr_idx;
    logic [15:0]        cnt;
    logic [WIDX_W-1:0]  word_idx;
    logic [IMEM_AW-1:0] wreg_q;
    logic [31:0]        wdat_q;

    logic               beat;
    logic               start_fire;
    logic               asm_accept;
    logic               word_full;
    logic [31:0]        asm_word;
    logic [7:0]         asm_chk;
    logic [15:0]        hdr_cnt;
    logic               last_word;
    logic [IMEM_AW-1:0] cur_addr;

    assign in_ready   = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
    assign beat       = in_valid & in_ready;
    assign start_fire = start & ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign asm_accept = beat & (state == S_DATA);
    assign hdr_cnt    = {in_data, cnt[7:0]};
    assign last_word  = ((16'(word_idx) + 16'd1) == cnt);
    assign cur_addr   = BASE_W + IMEM_AW'(word_idx);

    imem_word_assembler u_asm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (start_fire),
        .accept    (asm_accept),
        .in_data   (in_data),
        .word      (asm_word),
        .chk       (asm_chk),
        .word_full (word_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (beat && (hdr_idx == 1'(HDR_BYTES - 1))) begin
                    if (hdr_cnt > DEPTH_W)       state_nxt = S_ERROR;
                    else if (hdr_cnt == 16'd0)   state_nxt = S_CHK;
                    else                         state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (beat && word_full) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_word ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (beat) state_nxt = (in_data == asm_chk) ? S_DONE : S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            hdr_idx  <= 1'b0;
            cnt      <= '0;
            word_idx <= '0;
            wreg_q   <= '0;
            wdat_q   <= '0;
        end else begin
            state <= state_nxt;
            if (start_fire) begin
                hdr_idx  <= 1'b0;
                cnt      <= '0;
                word_idx <= '0;
            end
            if ((state == S_HDR) && beat) begin
                if (hdr_idx == 1'b0) cnt[7:0]  <= in_data;
                else                 cnt[15:8] <= in_data;
                hdr_idx <= 1'b1;
            end
            if (state == S_WRITE) begin
                word_idx <= word_idx + 1'b1;
                wreg_q   <= cur_addr;
                wdat_q   <= asm_word;
            end
        end
    end

    // Outputs show the live word during WRITE and hold the last written word afterwards
    assign RegWrite  = (state == S_WRITE);
    assign WriteReg  = RegWrite ? cur_addr : wreg_q;
    assign WriteData = RegWrite ? asm_word : wdat_q;
    assign busy      = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE) || (state == S_CHK);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int BASE  = 0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_nbytes;

    logic [7:0]  got_byte[$];
    int          got_byte_cyc[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_wr_cyc[$];
    int          rdy_viol = 0;
    int          b0, w0, v0;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Passive monitor: every consumed byte and every write pulse
    always @(negedge clock) begin
        if (reset_n) begin
            if (in_valid && in_ready) begin
                got_byte.push_back(in_data);
                got_byte_cyc.push_back(cyc);
            end
            if (RegWrite) begin
                got_addr.push_back(WriteReg);
                got_data.push_back(WriteData);
                got_wr_cyc.push_back(cyc);
                if (in_ready) rdy_viol++;
            end
        end
    end

    task automatic make_frame(input int n, input bit bad);
        logic [7:0] x, b;
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    task automatic set_nominal();
        frame = '{8'h02, 8'h00, 8'hB3, 8'h00, 8'hA2, 8'h00, 8'h33, 8'h01, 8'h12, 8'h40, 8'h71};
    endtask

    // Reference: what a correct loader must do with the current frame
    task automatic model_frame();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'({frame[1], frame[0]});
        if (n > DEPTH) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_nbytes = 2;
        end else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                w = 32'h0;
                for (int j = 0; j < 4; j++) begin
                    w = w + (32'(frame[2 + 4*i + j]) << (8 * j));
                    x ^= frame[2 + 4*i + j];
                end
                exp_addr.push_back(32'(BASE + i));
                exp_data.push_back(w);
            end
            exp_nbytes = 2 + 4 * n + 1;
            exp_done   = (frame[2 + 4*n] == x);
            exp_err    = !exp_done;
        end
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        b0 = got_byte.size(); w0 = got_addr.size(); v0 = rdy_viol;
        start = 1'b1; in_valid = 1'b1; in_data = frame[0];
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL start_ready: in_ready=%b required 0", in_ready);
        end
        @(posedge clock); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL start_busy: busy=%b required 1", busy);
        end
    endtask

    task automatic drive_bytes(input int nb, input bit gap, input bit rs);
        bit acc;
        int guard;
        for (int k = 0; k < nb; k++) begin
            if (gap) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0; start = 1'b0;
                    @(posedge clock); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = frame[k];
            start    = rs ? 1'($urandom_range(0, 1)) : 1'b0;
            acc = 1'b0; guard = 0;
            while (!acc && guard < 64) begin
                @(negedge clock);
                acc = in_ready;
                @(posedge clock); #1;
                guard++;
            end
            if (!acc) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: byte %0d not accepted, required acceptance", k);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (guard < 40) begin
            @(negedge clock);
            if (!busy) break;
            guard++;
        end
        if (guard >= 40) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic check_load(input string name);
        int nw, nbt, bi;
        nw  = got_addr.size() - w0;
        nbt = got_byte.size() - b0;
        n_checks++;
        if (nw != exp_addr.size()) begin
            n_fail++; $display("FAIL %s wr_count: got %0d required %0d", name, nw, exp_addr.size());
        end
        for (int i = 0; i < nw && i < exp_addr.size(); i++) begin
            n_checks++;
            if (got_addr[w0+i] !== exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL %s write%0d: got %h@%h required %h@%h", name, i,
                         got_data[w0+i], got_addr[w0+i], exp_data[i], exp_addr[i]);
            end
            bi = b0 + 4*i + 5;
            if (bi < got_byte_cyc.size()) begin
                n_checks++;
                if (got_wr_cyc[w0+i] != got_byte_cyc[bi] + 1) begin
                    n_fail++;
                    $display("FAIL %s latency%0d: write cycle %0d required %0d", name, i,
                             got_wr_cyc[w0+i], got_byte_cyc[bi] + 1);
                end
            end
        end
        n_checks++;
        if (nbt != exp_nbytes) begin
            n_fail++; $display("FAIL %s byte_count: got %0d required %0d", name, nbt, exp_nbytes);
        end
        for (int k = 0; k < nbt && k < exp_nbytes; k++) begin
            n_checks++;
            if (got_byte[b0+k] !== frame[k]) begin
                n_fail++; $display("FAIL %s byte%0d: got %h required %h", name, k, got_byte[b0+k], frame[k]);
            end
        end
        n_checks++;
        if (rdy_viol != v0) begin
            n_fail++; $display("FAIL %s ready_in_write: %0d cycles with in_ready=1 required 0", name, rdy_viol - v0);
        end
        n_checks++;
        if (done !== exp_done || error !== exp_err || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s flags: done=%b error=%b busy=%b in_ready=%b required %b %b 0 0",
                     name, done, error, busy, in_ready, exp_done, exp_err);
        end
    endtask

    task automatic run_load(input string name, input bit gap, input bit rs);
        model_frame();
        pulse_start();
        drive_bytes(exp_nbytes, gap, rs);
        wait_idle();
        check_load(name);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #3;
        n_checks++;
        if ({in_ready, RegWrite, busy, done, error} !== 5'b0 || WriteReg !== 32'h0 || WriteData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
                     in_ready, RegWrite, busy, done, error, WriteReg, WriteData);
        end
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_nominal();
        set_nominal();
        run_load("nominal", 1'b0, 1'b0);
        n_checks++;
        if (got_addr.size() < w0 + 2 || got_data[w0] !== 32'h00A200B3 || got_data[w0+1] !== 32'h40120133
            || got_addr[w0] !== 32'd0 || got_addr[w0+1] !== 32'd1 || done !== 1'b1) begin
            n_fail++; $display("FAIL nominal_const: words/addresses/done not as required (00a200b3@0, 40120133@1, done=1)");
        end
    endtask

    task automatic test_backpressure();
        set_nominal();
        run_load("gaps_nominal", 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            make_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
            run_load("gaps_random", 1'b1, 1'b1);
        end
    endtask

    task automatic test_empty();
        frame = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        frame = '{8'h21, 8'h00};
        model_frame();
        pulse_start();
        drive_bytes(2, 1'b0, 1'b0);
        n_checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overflow_now: error=%b in_ready=%b busy=%b required 1 0 0", error, in_ready, busy);
        end
        wait_idle();
        check_load("overflow33");
        frame = '{8'h00, 8'h01};
        run_load("overflow256", 1'b0, 1'b0);
        make_frame(DEPTH, 1'b0);
        run_load("full_depth", 1'b1, 1'b0);
    endtask

    task automatic test_bad_chk();
        set_nominal();
        frame[10] = 8'h70;
        run_load("bad_chk", 1'b0, 1'b0);
        set_nominal();
        run_load("reload", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_nominal();
        model_frame();
        pulse_start();
        drive_bytes(5, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, RegWrite, busy, done, error} !== 5'b0 || WriteReg !== 32'h0 || WriteData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%b we=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
                     in_ready, RegWrite, busy, done, error, WriteReg, WriteData);
        end
        @(negedge clock); @(negedge clock);
        reset_n = 1'b1;
        run_load("after_reset", 1'b0, 1'b0);
        n_checks++;
        if (got_addr.size() <= w0 || got_addr[w0] !== 32'd0) begin
            n_fail++; $display("FAIL after_reset_addr0: first write address not 0 as required");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_empty();
        test_overflow();
        test_bad_chk();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
